// File: rtl/sevenseg_sequence_decoder.sv
// Rebuilds decimal numbers from digit glyphs shown in sequence on a 7-segment bus.
// Optional SEG_SYNC_EN macro inserts a 2-flop synchroniser on seg_in.
module sevenseg_sequence_decoder #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 16,
    parameter int MAX_DIGITS  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [7:0] value_out,
    output logic       value_valid,
    output logic [1:0] digit_count,
    output logic       err_pulse
);

    localparam int SW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, CAND, HELD, GAP, ERR} state_t;

    state_t        state, state_n;
    logic [6:0]    seg, prev_seg;
    logic [SW-1:0] stable_cnt, stable_now;
    logic [GW-1:0] gap_cnt, gap_n;
    logic [9:0]    acc, acc_n;
    logic [1:0]    cnt_n;
    logic          load, err_n;
    logic          same, blank, glyph_ok, gap_done;
    logic [4:0]    dec;
    logic [11:0]   prod;

    // Returns {valid, digit}; any pattern outside the ten digit glyphs is invalid.
    function automatic logic [4:0] decode(input logic [6:0] g);
        case (g)
            7'h3F: return 5'h10;
            7'h06: return 5'h11;
            7'h5B: return 5'h12;
            7'h4F: return 5'h13;
            7'h66: return 5'h14;
            7'h6D: return 5'h15;
            7'h7D: return 5'h16;
            7'h07: return 5'h17;
            7'h7F: return 5'h18;
            7'h6F: return 5'h19;
            default: return 5'h00;
        endcase
    endfunction

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] c);
        if (c >= SW'(HOLD_CYCLES)) return SW'(HOLD_CYCLES);
        else return c + 1'b1;
    endfunction

`ifdef SEG_SYNC_EN
    logic [6:0] sync_p0, sync_p1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= seg_in;
            sync_p1 <= sync_p0;
        end
    end
    assign seg = sync_p1;
`else
    assign seg = seg_in;
`endif

    assign same       = (seg == prev_seg);
    assign blank      = (seg == 7'h00);
    assign stable_now = same ? sat_inc(stable_cnt) : SW'(1);
    assign dec        = decode(seg);
    assign glyph_ok   = dec[4];
    assign prod       = 12'(acc) * 12'd10 + 12'(dec[3:0]);
    // True when the current blank sample is the GAP_CYCLES-th in a row.
    assign gap_done   = (gap_cnt == GW'(GAP_CYCLES - 1));

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = digit_count;
        gap_n   = gap_cnt;
        load    = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: if (!blank && !same) state_n = CAND;
            CAND: begin
                if (blank) begin
                    gap_n   = GW'(1);
                    state_n = (digit_count != 2'd0) ? GAP : IDLE;
                end else if (same && stable_now == SW'(HOLD_CYCLES)) begin
                    if (!glyph_ok || int'(digit_count) >= MAX_DIGITS || prod > 12'd255) begin
                        state_n = ERR;
                        acc_n   = '0;
                        cnt_n   = '0;
                        gap_n   = '0;
                        err_n   = 1'b1;
                    end else begin
                        state_n = HELD;
                        acc_n   = prod[9:0];
                        cnt_n   = digit_count + 1'b1;
                    end
                end
            end
            HELD: begin
                if (blank) begin
                    state_n = GAP;
                    gap_n   = GW'(1);
                end else if (!same) begin
                    state_n = CAND;
                end
            end
            GAP: begin
                if (!blank) begin
                    state_n = CAND;
                    gap_n   = '0;
                end else if (gap_done) begin
                    load    = (digit_count != 2'd0);
                    acc_n   = '0;
                    cnt_n   = '0;
                    gap_n   = '0;
                    state_n = IDLE;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            ERR: begin
                if (!blank) begin
                    gap_n = '0;
                end else if (gap_done) begin
                    gap_n   = '0;
                    state_n = IDLE;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prev_seg    <= '0;
            stable_cnt  <= '0;
            gap_cnt     <= '0;
            acc         <= '0;
            digit_count <= '0;
            value_out   <= '0;
            value_valid <= 1'b0;
            err_pulse   <= 1'b0;
        end else begin
            state       <= state_n;
            prev_seg    <= seg;
            stable_cnt  <= stable_now;
            gap_cnt     <= gap_n;
            acc         <= acc_n;
            digit_count <= cnt_n;
            value_valid <= load;
            err_pulse   <= err_n;
            if (load) value_out <= acc[7:0];
        end
    end

endmodule

// File: tb/tb_sevenseg_sequence_decoder.sv
// Directed bench for sevenseg_sequence_decoder (default build, no input synchroniser).
module tb_sevenseg_sequence_decoder;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_in;
    logic [7:0] value_out;
    logic       value_valid;
    logic [1:0] digit_count;
    logic       err_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int vcount = 0;
    int ecount = 0;
    int both = 0;
    int v0, e0;

    sevenseg_sequence_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .value_out   (value_out),
        .value_valid (value_valid),
        .digit_count (digit_count),
        .err_pulse   (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (value_valid) vcount = vcount + 1;
        if (err_pulse) ecount = ecount + 1;
        if (value_valid && err_pulse) both = both + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Hold pattern p for n sample edges; returns 1 time unit after the last edge.
    task automatic show(input logic [6:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            seg_in = p;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mark();
        v0 = vcount;
        e0 = ecount;
    endtask

    initial begin
        rst_n  = 1'b0;
        seg_in = 7'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_value", value_out, 0);
        check("rst_valid", value_valid, 0);
        check("rst_count", digit_count, 0);
        check("rst_err", err_pulse, 0);
        rst_n = 1'b1;
        show(7'h00, 2);

        // Single digit "3" with exact latency
        mark();
        show(7'h4F, 4);
        check("c1_count_mid", digit_count, 1);
        show(7'h00, 15);
        check("c1_valid_early", value_valid, 0);
        show(7'h00, 1);
        check("c1_valid_on_time", value_valid, 1);
        check("c1_value", value_out, 3);
        check("c1_count_end", digit_count, 0);
        show(7'h00, 3);
        check("c1_pulses", vcount - v0, 1);

        // "11" with short blank between repeated digits
        mark();
        show(7'h06, 4); show(7'h00, 2); show(7'h06, 4); show(7'h00, 18);
        check("c2_pulses", vcount - v0, 1);
        check("c2_value", value_out, 11);
        mark();
        show(7'h06, 4); show(7'h00, 18);
        check("c2b_value", value_out, 1);
        check("c2b_pulses", vcount - v0, 1);

        // 2,9,3 -> 293 overflows on the third digit
        mark();
        show(7'h5B, 4); show(7'h6F, 4); show(7'h4F, 4); show(7'h00, 18);
        check("c3_err", ecount - e0, 1);
        check("c3_novalid", vcount - v0, 0);
        mark();
        show(7'h66, 4); show(7'h6D, 4); show(7'h7F, 4); show(7'h00, 18);
        check("c3b_err", ecount - e0, 1);
        check("c3b_novalid", vcount - v0, 0);
        mark();
        show(7'h5B, 4); show(7'h6D, 4); show(7'h00, 1); show(7'h6D, 4); show(7'h00, 18);
        check("c3c_value", value_out, 255);
        check("c3c_pulses", vcount - v0, 1);
        check("c3c_noerr", ecount - e0, 0);

        // Invalid glyph, digits ignored in error state, then recovery
        mark();
        show(7'h12, 4); show(7'h00, 2);
        check("c4_err_once", ecount - e0, 1);
        show(7'h4F, 4); show(7'h00, 18);
        check("c4_ignored", vcount - v0, 0);
        check("c4_value_kept", value_out, 255);
        show(7'h07, 4); show(7'h00, 18);
        check("c4_value", value_out, 7);
        check("c4_pulses", vcount - v0, 1);

        // Hold not met
        mark();
        show(7'h7D, 3); show(7'h00, 18);
        check("c5_nopulse", vcount - v0, 0);
        check("c5_noerr", ecount - e0, 0);
        check("c5_value_kept", value_out, 7);

        // Reset in the gap after "4","2"
        mark();
        show(7'h66, 4); show(7'h5B, 4); show(7'h00, 5);
        check("c6_count_pre", digit_count, 2);
        rst_n = 1'b0;
        #1;
        check("c6_rst_value", value_out, 0);
        check("c6_rst_count", digit_count, 0);
        check("c6_rst_valid", value_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        show(7'h00, 20);
        check("c6_nopulse", vcount - v0, 0);
        check("c6_noerr", ecount - e0, 0);
        check("c6_value", value_out, 0);

        check("never_both", both, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
